// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive-side demultiplexer.
package tdm_pkg;

    typedef enum logic {HUNT, RUN} tdm_state_t;

    localparam int DEFAULT_N_CH = 4;
    localparam int DEFAULT_W    = 8;

endpackage

// File: rtl/tdm_slot_deserializer.sv
// Per-slot serial-to-parallel converter: MSB-first shift register plus bit counter.
module tdm_slot_deserializer
    import tdm_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_bit,
    input  logic         i_shift,
    input  logic         i_restart,
    input  logic         i_clear,
    output logic [W-1:0] o_word,
    output logic         o_slot_first,
    output logic         o_slot_last
);

    localparam int              BW      = $clog2(W);
    localparam logic [BW-1:0]   LAST_B  = BW'(W - 1);

    // The final bit of a slot is taken straight from i_bit, so only W-1 earlier bits are stored.
    logic [W-2:0]  r_shift;
    logic [BW-1:0] r_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_bit   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_bit   <= '0;
        end else if (i_restart) begin
            r_shift <= (W-1)'(i_bit);
            r_bit   <= BW'(1);
        end else if (i_shift) begin
            r_shift <= (W-1)'({r_shift, i_bit});
            r_bit   <= (r_bit == LAST_B) ? '0 : r_bit + BW'(1);
        end
    end

    assign o_word       = {r_shift, i_bit};
    assign o_slot_first = (r_bit == '0);
    assign o_slot_last  = (r_bit == LAST_B);

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks on the frame marker, deserializes each slot
// into its channel register and flags framing violations.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = DEFAULT_N_CH,
    parameter int W    = DEFAULT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_bit,
    input  logic                   i_bit_en,
    input  logic                   i_frame,
    output logic [N_CH-1:0][W-1:0] o_data,
    output logic [N_CH-1:0]        o_ch_valid,
    output logic                   o_frame_done,
    output logic                   o_locked,
    output logic                   o_sync_err
);

    localparam int            CW      = $clog2(N_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    tdm_state_t r_state;
    tdm_state_t w_next;

    logic [CW-1:0]          r_slot;
    logic [N_CH-1:0][W-1:0] r_data;
    logic [N_CH-1:0]        r_ch_valid;
    logic                   r_frame_done;
    logic                   r_sync_err;

    logic         w_shift;
    logic         w_restart;
    logic         w_clear;
    logic         w_write;
    logic         w_err;
    logic [W-1:0] w_word;
    logic         w_slot_first;
    logic         w_slot_last;

    tdm_slot_deserializer #(.W(W)) u_deser (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_bit        (i_bit),
        .i_shift      (w_shift),
        .i_restart    (w_restart),
        .i_clear      (w_clear),
        .o_word       (w_word),
        .o_slot_first (w_slot_first),
        .o_slot_last  (w_slot_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // A marker anywhere but the frame start wins over slot completion: the partial slot is dropped.
    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_restart = 1'b0;
        w_clear   = 1'b0;
        w_write   = 1'b0;
        w_err     = 1'b0;
        if (i_bit_en) begin
            case (r_state)
                HUNT: begin
                    if (i_frame) begin
                        w_restart = 1'b1;
                        w_next    = RUN;
                    end
                end
                RUN: begin
                    if (w_slot_first && (r_slot == '0)) begin
                        if (i_frame) begin
                            w_shift = 1'b1;
                        end else begin
                            w_err   = 1'b1;
                            w_clear = 1'b1;
                            w_next  = HUNT;
                        end
                    end else if (i_frame) begin
                        w_err     = 1'b1;
                        w_restart = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        w_write = w_slot_last;
                    end
                end
                default: w_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot       <= '0;
            r_data       <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= w_err;
            if (w_restart || w_clear) begin
                r_slot <= '0;
            end else if (w_write) begin
                r_data[r_slot] <= w_word;
                r_ch_valid     <= N_CH'(1) << r_slot;
                r_frame_done   <= (r_slot == LAST_CH);
                r_slot         <= (r_slot == LAST_CH) ? '0 : r_slot + CW'(1);
            end
        end
    end

    assign o_data       = r_data;
    assign o_ch_valid   = r_ch_valid;
    assign o_frame_done = r_frame_done;
    assign o_sync_err   = r_sync_err;
    assign o_locked     = (r_state == RUN);

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side time-division demultiplexer: takes a serial bit stream that carries N_CH channels of W-bit words per frame and routes each word to its own output register. It is the far end of the 2:1/N:1 mux datapath used to share one wire between sources. The block locks on a frame marker and deserializes each slot. It registers each word per channel and flags framing errors.

## Interface
- N_CH, 4: channels per frame (≥2)
- W, 8: bits per channel slot (≥2)
- i_clk  in  1  single clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_bit  in  1  serial data bit, MSB of each slot first
- i_bit_en  in  1  i_bit/i_frame valid this cycle; when low the block holds all state
- i_frame  in  1  asserted with the first bit (slot 0, MSB) of every frame; qualified by i_bit_en
- o_data  out  N_CH×W  packed per-channel word registers; o_data[c] holds channel c's last word
- o_ch_valid  out  N_CH  one-hot, one-cycle pulse: o_data[c] updated this cycle
- o_frame_done  out  1  one-cycle pulse coincident with o_ch_valid[N_CH-1]
- o_locked  out  1  high while in RUN
- o_sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT, RUN.
- The state machine ignores a cycle with i_bit_en low; only pulse outputs drop to 0 that cycle.
- HUNT:
  - Discard bits until i_frame=1.
  - That bit is captured as bit 0 of slot 0. Go to RUN.
- RUN:
  - Shift i_bit into a W-bit shift register, MSB first.
  - Bit index b runs 0..W-1. Slot index c runs 0..N_CH-1.
- End of slot (b=W-1):
  - Write the completed word (including the current bit) to o_data[c] and pulse o_ch_valid[c].
  - Reset b to 0 and advance c. c wraps from N_CH-1 to 0.
  - When c=N_CH-1, also pulse o_frame_done.
- Expected-frame check, at each enabled cycle where b=0 and c=0:
  - i_frame=0: pulse o_sync_err, go to HUNT, discard the bit, leave o_data unchanged.
  - i_frame=1: normal.
- Unexpected marker, i_frame=1 at any other position:
  - Pulse o_sync_err and abandon the partial slot with no write for it.
  - Restart at b=0, c=0 with this bit as slot 0 bit 0. Stay in RUN.
- o_data[c] changes only on its own slot completion. Other channels hold.
- Counter widths: b is $clog2(W) bits and c is $clog2(N_CH) bits. Explicit wrap compares; no reliance on natural overflow.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert usage):
  - o_data all 0; o_ch_valid 0; o_frame_done 0; o_locked 0; o_sync_err 0.
  - State HUNT; b=0, c=0; shift register 0.
- Latency: the last bit of slot c is sampled at edge k, and o_data[c] and o_ch_valid[c] are visible after edge k (registered, one edge).
- Minimum frame: N_CH·W enabled cycles. Back-to-back frames need no idle gap.
- o_locked rises after the edge that samples the first i_frame in HUNT. It falls after the edge that detects a missing marker.
- o_sync_err and o_locked come from the same edge.
- Reset mid-frame: immediate return to reset values; the partial word is lost.
- Simultaneous end-of-slot and i_frame=1 when b=W-1 with c≠N_CH-1 or c=N_CH-1: i_frame wins. Record an error and restart, with no o_data write.

## Structure
- tdm_pkg:
  - typedef enum logic {HUNT, RUN} tdm_state_t.
  - Default N_CH/W localparams.
- Sub-module tdm_slot_deserializer:
  - Contains the W-bit shift register and bit counter, with shift enable and clear.
  - Outputs the word and a slot_last flag.
- Top level holds the FSM, the slot counter, the output register bank and the pulse generation.

## Test plan
- Reset then 1 clean frame (N_CH=4, W=8; words 0xA5, 0x3C, 0xFF, 0x01; i_frame on first bit):
  - o_ch_valid pulses 0001, 0010, 0100, 1000, each 8 enabled cycles apart.
  - o_data = {01,FF,3C,A5}; o_frame_done with the last; o_locked=1.
- Bits before the first marker (10 random bits, then a frame): all discarded, no pulses until slot 0 completes; o_data matches the frame only.
- i_bit_en gaps (0 inserted every other cycle within a frame): identical o_data; pulses occur only on enabled cycles; the count of enabled cycles per slot stays 8.
- Missing marker (second frame sent without i_frame): o_sync_err pulse at its first bit; o_locked→0; o_data holds frame-1 values; relocks on the next marker.
- Early marker (i_frame at bit 3 of slot 2): o_sync_err pulse; no write to channel 2; decoding restarts with that bit as slot 0 bit 0.
- Async reset mid-slot 1: all outputs 0 immediately without a clock edge; HUNT after release.
